// File: rtl/sram_sequencer.sv
// Command sequencer driving an SRAM bridge with SETUP / ACCESS / HOLD strobe timing.
// Supports single-byte read/write, multi-byte fill and no-op commands; all outputs registered.
module sram_sequencer #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              busy,
  output logic              m_chipselect_n,
  output logic              m_read_n,
  output logic              m_write_n,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_NOP  = 2'b11;
  localparam logic [3:0] LP_W    = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_cfg
    $error("sram_sequencer: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_op, w_op;
  logic [ADDR_W-1:0] r_len, w_len;
  logic [3:0]        r_cnt, w_cnt;
  logic              r_ready, r_busy, r_done, r_rsp_valid;
  logic              r_cs_n, r_rd_n, r_wr_n;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata, r_rdata, w_rdata;
  logic              w_accept, w_done, w_rsp_valid;

  assign w_accept = cmd_valid && (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && cmd_op != OP_NOP) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == LP_W) w_next = S_HOLD;
      S_HOLD:   w_next = (r_op == 2'b10 && r_len != '0) ? S_SETUP : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the upcoming state
  always_comb begin
    w_op        = r_op;
    w_len       = r_len;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_cnt       = r_cnt;
    w_done      = (w_accept && cmd_op == OP_NOP) || (r_state == S_HOLD && w_next == S_IDLE);
    w_rsp_valid = (r_state == S_ACCESS) && (w_next == S_HOLD) && (r_op == OP_RD);
    w_rdata     = w_rsp_valid ? m_readdata : r_rdata;
    if (w_accept) begin
      w_op = cmd_op;
      if (cmd_op != OP_NOP) begin
        w_addr  = cmd_addr;
        w_wdata = cmd_data;
        w_len   = cmd_len;
      end
    end
    if (r_state == S_SETUP)       w_cnt = 4'd1;
    else if (r_state == S_ACCESS) w_cnt = r_cnt + 4'd1;
    // Fill advances to the next byte only at the end of HOLD; address wraps naturally
    if (r_state == S_HOLD && w_next == S_SETUP) begin
      w_len  = r_len - ADDR_W'(1);
      w_addr = r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= OP_NOP;
      r_len       <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
    end else begin
      r_op        <= w_op;
      r_len       <= w_len;
      r_cnt       <= w_cnt;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_rdata     <= w_rdata;
      r_ready     <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= w_done;
      r_rsp_valid <= w_rsp_valid;
      r_cs_n      <= (w_next == S_IDLE);
      r_rd_n      <= !((w_next == S_ACCESS) && (w_op == OP_RD));
      r_wr_n      <= !((w_next == S_ACCESS) && (w_op != OP_RD));
    end
  end

  assign cmd_ready      = r_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rdata;
  assign m_chipselect_n = r_cs_n;
  assign m_read_n       = r_rd_n;
  assign m_write_n      = r_wr_n;
  assign m_address      = r_addr;
  assign m_writedata    = r_wdata;

endmodule

// File: doc/sram_sequencer.md
# sram_sequencer

Command sequencer that sits directly upstream of the SRAM bus bridge and drives its active-low chip-select, read and write strobes with a fixed setup/access/hold cycle structure. It accepts read, write and fill commands over a valid/ready handshake. It returns read data with a one-cycle valid pulse and signals command completion. The fill command writes a constant byte over an address range, used to clear display/frame memory after reset.

## Interface
Parameters:
- ADDR_W, 17, SRAM byte address width
- DATA_W, 8, SRAM data width
- WAIT_CYCLES, 1, cycles the read/write strobe is held low per access; legal range 1..15

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 read, 01 write, 10 fill, 11 no-op
- cmd_addr  in  ADDR_W  start address
- cmd_data  in  DATA_W  write/fill byte
- cmd_len  in  ADDR_W  fill only: bytes written = cmd_len+1
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  DATA_W  last read byte, held until next read
- done  out  1  one-cycle pulse, command finished
- busy  out  1  high whenever state is not IDLE
- m_chipselect_n  out  1  to bridge s_chipselect_n
- m_read_n  out  1  to bridge s_read_n
- m_write_n  out  1  to bridge s_write_n
- m_address  out  ADDR_W  to bridge s_address
- m_writedata  out  DATA_W  to bridge s_writedata
- m_readdata  in  DATA_W  from bridge s_readdata

## Operation
- States: IDLE, SETUP, ACCESS, HOLD. All outputs registered.
- IDLE: cmd_ready=1, all strobes high. A command is accepted on the edge where cmd_valid && cmd_ready. The sequencer latches op, addr, data and len.
- Op 11 is accepted without SRAM activity. done pulses in the cycle after acceptance. The sequencer stays in IDLE.
- Op 00/01/10 go to SETUP.
- SETUP, 1 cycle: m_chipselect_n=0. m_address and m_writedata are driven. m_read_n and m_write_n stay high.
- ACCESS, WAIT_CYCLES cycles: the chip-select stays low. Read asserts m_read_n=0; write/fill assert m_write_n=0. A 4-bit counter counts ACCESS cycles.
- Read capture: m_readdata is sampled into rsp_data on the edge that ends the last ACCESS cycle.
- HOLD, 1 cycle: strobes are high, chip-select stays low, address and data are unchanged. For reads, rsp_valid=1 in this cycle.
- After HOLD, read/write: go to IDLE, and done=1 in the first IDLE cycle.
- After HOLD, fill with remaining count > 0: decrement the count, set address+1 (modulo 2^ADDR_W, so 0x1FFFF wraps to 0x00000), go to SETUP.
- After HOLD, fill with remaining count == 0: go to IDLE with done as for read/write.
- m_address and m_writedata hold their last values in IDLE. The chip-select goes high in IDLE.
- Reset, asynchronous, at any time including mid-fill:
  - state goes to IDLE; the pending command is discarded with no done pulse.
  - m_chipselect_n, m_read_n, m_write_n = 1.
  - m_address = 0, m_writedata = 0, rsp_data = 0.
  - rsp_valid, done, busy = 0; cmd_ready = 1 after reset is released.
- WAIT_CYCLES outside 1..15 is a configuration error, flagged by a simulation-only assertion.

## Timing
- Let W = WAIT_CYCLES and let acceptance happen on edge 0.
- Read or write:
  - SETUP is cycle 1.
  - ACCESS is cycles 2..W+1.
  - HOLD is cycle W+2; rsp_valid for a read is in this cycle.
  - IDLE with done and cmd_ready=1 is cycle W+3.
- Back-to-back command rate: one per W+3 cycles.
- Fill of N = cmd_len+1 bytes: N×(W+2) cycles from SETUP to the last HOLD. There is no IDLE between bytes. done comes one cycle after the last HOLD.
- m_write_n/m_read_n never fall in the same cycle that m_chipselect_n falls or that the address changes. They never rise later than one cycle before the address changes.
- cmd_valid held while cmd_ready=0 is not consumed. The command is accepted on the first IDLE edge.

## Test plan
- Reset: assert reset mid-cycle with no clock edge -> all strobes read 1, m_address=0, rsp_data=0, busy=0 immediately. After release, cmd_ready=1.
- Write, W=1, addr 0x00A5, data 0x3C:
  - m_chipselect_n low for cycles 1..3.
  - m_write_n low only in cycle 2.
  - m_address=0x00A5 and m_writedata=0x3C held for cycles 1..3.
  - done in cycle 4.
- Read, W=3, from an SRAM model holding 0x5A at 0x1F000 -> m_read_n low in cycles 2..4, rsp_valid in cycle 5 with rsp_data=0x5A, done in cycle 6.
- Fill, W=1, addr 0x1FFFE, len 3, data 0xFF -> writes 0xFF to 0x1FFFE, 0x1FFFF, 0x00000 and 0x00001 with one m_write_n pulse each, 12 cycles total, a single done.
- Command issued while busy: second write held on cmd_valid during the first read -> cmd_ready=0 until cycle W+3, second write accepted there, first read data unaffected.
- Reset mid-fill (after 2 of 8 bytes) -> strobes high asynchronously, no done pulse, remaining addresses untouched in the model. Then op 11 -> done the next cycle, no strobe activity.
